// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM states,
// port index constants, default RAM limit and the address range check.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DMA  = 1;

    localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_0800;

    // An access is serviced only if it lies inside RAM and is word aligned.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] limit);
        return (addr < limit) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on a conflict the port
// that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant decided purely from the current requests.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port data RAM between the core load/store port
// (port 0) and the loader/DMA port (port 1), with optional bus locking.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_lock,
    output logic [1:0]  rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    input  logic [31:0] mem_data_out
);

    localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [63:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_err_q, rsp_err_d;

    logic [1:0]        rr_grant;
    logic [1:0]        grant;
    logic              xfer;
    logic              gidx;
    logic [31:0]       g_addr;
    logic [31:0]       g_wdata;
    logic              g_we;
    logic              g_lock;
    logic              g_in_range;

    rr_arb2 u_rr (
        .valid (req_valid),
        .last  (last_grant_q),
        .grant (rr_grant)
    );

    // Grant selection: round-robin when idle, owner only while locked.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            case (state_q)
                IDLE:    grant = rr_grant;
                OWN0:    grant = {1'b0, req_valid[PORT_CORE]};
                OWN1:    grant = {req_valid[PORT_DMA], 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    // Granted-port mux and RAM-side controls.
    always_comb begin
        xfer        = |grant;
        gidx        = grant[PORT_DMA];
        g_addr      = gidx ? req_addr[63:32]  : req_addr[31:0];
        g_wdata     = gidx ? req_wdata[63:32] : req_wdata[31:0];
        g_we        = req_we[gidx];
        g_lock      = req_lock[gidx];
        g_in_range  = addr_in_range(g_addr, ADDR_LIMIT);
        mem_address = '0;
        mem_data_in = '0;
        mem_we      = 1'b0;
        if (xfer) begin
            mem_address = {g_addr[31:2], 2'b00};
            mem_data_in = g_wdata;
            mem_we      = g_we & g_in_range;
        end
    end

    // Next state, lock counter and round-robin history.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                lock_cnt_d = '0;
                if (xfer) begin
                    last_grant_d = gidx;
                    if (g_lock) state_d = gidx ? OWN1 : OWN0;
                end
            end
            OWN0, OWN1: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                if (xfer) begin
                    last_grant_d = gidx;
                    if (!g_lock) begin
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end
                end
                // Lock budget exhausted: release and let the other port win next.
                if (lock_cnt_q == CNT_LAST) begin
                    state_d      = IDLE;
                    lock_cnt_d   = '0;
                    last_grant_d = (state_q == OWN1);
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Response for the transfer of this cycle, presented on the next cycle.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = '0;
        if (xfer) begin
            rsp_valid_d[gidx] = 1'b1;
            rsp_err_d[gidx]   = ~g_in_range;
            if (!g_we && g_in_range) begin
                if (gidx) rsp_rdata_d[63:32] = mem_data_out;
                else      rsp_rdata_d[31:0]  = mem_data_out;
            end
        end
    end

    // State registers; reset drops ownership and any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lock_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_0800, is the first byte address outside data RAM.
REQ-002 Parameter LOCK_MAX, default 16, is the maximum number of cycles a locked owner may hold the RAM.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-port request valid; bit 0 is the core load/store port, bit 1 is the loader/DMA port.
REQ-006 req_ready  output  2  per-port grant; a transfer occurs on req_valid[i] & req_ready[i].
REQ-007 req_we  input  2  per-port write enable (1 = store, 0 = load).
REQ-008 req_addr  input  2x32  per-port byte address.
REQ-009 req_wdata  input  2x32  per-port store data.
REQ-010 req_lock  input  2  per-port request to keep ownership after this transfer.
REQ-011 rsp_valid  output  2  per-port response strobe, one cycle wide.
REQ-012 rsp_rdata  output  2x32  per-port load data, valid with rsp_valid.
REQ-013 rsp_err  output  2  per-port error flag, valid with rsp_valid.
REQ-014 mem_address  output  32  word-aligned byte address to the data RAM.
REQ-015 mem_data_in  output  32  store data to the data RAM.
REQ-016 mem_we  output  1  RAM write enable.
REQ-017 mem_data_out  input  32  combinational RAM read data.

Function
REQ-018 At most one bit of req_ready SHALL be high in any cycle, and it SHALL be decided combinationally in the same cycle as req_valid.
REQ-019 The FSM SHALL have states IDLE, OWN0 and OWN1.
REQ-020 In IDLE, a single valid port SHALL be granted; if both are valid, the port not granted last (last_grant register) SHALL be granted.
REQ-021 In OWNi, only port i SHALL be granted, and port 1-i SHALL see req_ready low.
REQ-022 A transfer with req_lock=1 SHALL move the FSM to OWNi (or keep it there).
REQ-023 A transfer with req_lock=0 SHALL return the FSM to IDLE.
REQ-024 The lock counter SHALL clear on entering OWNi and increment each cycle in OWNi.
REQ-025 When the lock counter reaches LOCK_MAX-1, the FSM SHALL be forced to IDLE regardless of req_lock, and last_grant SHALL be set to i.
REQ-026 mem_address and mem_data_in SHALL follow the granted port; with no grant both SHALL be 0.
REQ-027 mem_we SHALL equal granted valid & req_we & in_range, where in_range = (addr < ADDR_LIMIT) & (addr[1:0] == 0).
REQ-028 A response SHALL be issued exactly one cycle after each transfer, for both reads and writes: rsp_valid[i]=1, with rsp_rdata[i] = mem_data_out registered at the transfer edge.
REQ-029 rsp_rdata SHALL be 0 for writes and for out-of-range accesses.
REQ-030 An out-of-range or misaligned access SHALL perform no write and SHALL return rsp_err=1.
REQ-031 Back-to-back transfers SHALL be sustained at one per cycle, with no bubble on a port change.
REQ-032 A read and a write to the same address in consecutive cycles SHALL return the pre-write data for the read and the new data for subsequent reads.

Reset
REQ-033 While rst_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_address=0, mem_data_in=0, FSM=IDLE, lock counter=0, last_grant=1 (port 0 wins the first conflict).
REQ-034 Reset asserted mid-lock or with a response pending SHALL drop ownership and the pending response; nothing SHALL be replayed after reset.

Structure
REQ-035 The shared package SHALL hold the FSM state enum, the port index constants (PORT_CORE=0, PORT_DMA=1) and the default ADDR_LIMIT.
REQ-036 The round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs: valid[1:0], last; output: one-hot grant), and the FSM, counter and response registers SHALL stay in dmem_arbiter.

Verification
REQ-037 Both ports valid in the first cycle after reset, port 0 reading 0x10 (holds 0xA5A5A5A5) and port 1 reading 0x20 -> port 0 granted in cycle 0, port 1 in cycle 1; rsp_rdata[0]=0xA5A5A5A5 one cycle after its grant.
REQ-038 Port 1 writes 0x12345678 to 0x40 with lock=1, then reads 0x40 with lock=0, while port 0 is continuously valid -> port 0 not granted until after the port-1 read; read returns 0x12345678.
REQ-039 Port 0 holds lock=1 for 20 cycles with LOCK_MAX=16 -> forced release after 16 cycles in OWN0; waiting port 1 granted the next cycle.
REQ-040 Port 0 writes to 0x800, then to 0x42 -> mem_we stays 0 for both; rsp_err[0]=1 for both; RAM contents unchanged.
REQ-041 rst_n pulsed low during OWN1 with a response pending -> all outputs 0 immediately; no rsp_valid after release; the first conflict after reset is won by port 0.
